// File: rtl/sd_init_seq.sv
// SD card SPI-mode initialisation sequencer: walks CMD0, CMD8, CMD58, CMD55/ACMD41
// and a final CMD58 through the SPI command engine, then reports card type.
module sd_init_seq #(
   parameter int POWERUP_CYCLES = 1000000,
   parameter int CMD0_TRIES     = 10,
   parameter int ACMD41_TRIES   = 1000,
   parameter int ACMD41_GAP     = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  err_code,
   output logic        card_sdhc,
   output logic        fast_clk,
   output logic        cs_n,
   output logic        eng_req,
   output logic [47:0] eng_cmd,
   output logic [5:0]  eng_resp_len,
   input  logic        eng_ack,
   input  logic        eng_done,
   input  logic        eng_timeout,
   input  logic [39:0] eng_resp
);
   localparam int C0W  = $clog2(CMD0_TRIES + 1);
   localparam int A41W = $clog2(ACMD41_TRIES + 1);
   localparam logic [C0W-1:0]  C0_LAST  = C0W'(CMD0_TRIES - 1);
   localparam logic [A41W-1:0] A41_LAST = A41W'(ACMD41_TRIES - 1);
   localparam logic [20:0]     PU_LAST  = 21'(POWERUP_CYCLES - 1);
   localparam logic [20:0]     GAP_LAST = 21'(ACMD41_GAP - 1);

   localparam logic [47:0] FR_CMD0     = 48'h40_00000000_95;
   localparam logic [47:0] FR_CMD8     = 48'h48_000001AA_87;
   localparam logic [47:0] FR_CMD58    = 48'h7A_00000000_FD;
   localparam logic [47:0] FR_CMD55    = 48'h77_00000000_65;
   localparam logic [47:0] FR_ACMD41V2 = 48'h69_40000000_77;
   localparam logic [47:0] FR_ACMD41V1 = 48'h69_00000000_E5;

   typedef enum logic [3:0] {
      IDLE, POWERUP, CMD0, CMD8, CMD58A, CMD55, ACMD41, GAP, CMD58B, DONE, ERROR
   } state_t;

   state_t            state_q, state_d;
   logic              wait_q, wait_d;
   logic              v1_q, v1_d;
   logic [20:0]       timer_q, timer_d;
   logic [C0W-1:0]    cmd0_cnt_q, cmd0_cnt_d;
   logic [A41W-1:0]   a41_cnt_q, a41_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [2:0]        err_code_q, err_code_d;
   logic              card_sdhc_q, card_sdhc_d;
   logic              fast_clk_q, fast_clk_d;
   logic              cs_n_q, cs_n_d;
   logic              eng_req_q, eng_req_d;
   logic [47:0]       eng_cmd_q, eng_cmd_d;
   logic [5:0]        eng_resp_len_q, eng_resp_len_d;

   logic [47:0]       frame;
   logic [5:0]        frame_len;
   logic [7:0]        r1;
   logic [2:0]        fail_code;
   logic              resp_unused;

   assign r1          = eng_resp[39:32];
   assign resp_unused = ^{eng_resp[31], eng_resp[29:22], eng_resp[19:12]};

   always_comb begin
      frame     = FR_CMD0;
      frame_len = 6'd8;
      case (state_q)
         CMD8:           begin frame = FR_CMD8;  frame_len = 6'd40; end
         CMD58A, CMD58B: begin frame = FR_CMD58; frame_len = 6'd40; end
         CMD55:          frame = FR_CMD55;
         ACMD41:         frame = v1_q ? FR_ACMD41V1 : FR_ACMD41V2;
         default:        ;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      v1_d           = v1_q;
      timer_d        = timer_q;
      cmd0_cnt_d     = cmd0_cnt_q;
      a41_cnt_d      = a41_cnt_q;
      busy_d         = busy_q;
      done_d         = done_q;
      error_d        = error_q;
      err_code_d     = err_code_q;
      card_sdhc_d    = card_sdhc_q;
      fast_clk_d     = fast_clk_q;
      cs_n_d         = cs_n_q;
      eng_req_d      = eng_req_q;
      eng_cmd_d      = eng_cmd_q;
      eng_resp_len_d = eng_resp_len_q;
      fail_code      = 3'd0;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d     = POWERUP;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_code_d  = 3'd0;
               card_sdhc_d = 1'b0;
               fast_clk_d  = 1'b0;
               cs_n_d      = 1'b1;
               timer_d     = '0;
            end
         end
         POWERUP: begin
            if (timer_q >= PU_LAST) begin
               timer_d    = '0;
               cs_n_d     = 1'b0;
               cmd0_cnt_d = '0;
               wait_d     = 1'b0;
               state_d    = CMD0;
            end else begin
               timer_d = timer_q + 21'd1;
            end
         end
         GAP: begin
            if (timer_q >= GAP_LAST) begin
               timer_d = '0;
               wait_d  = 1'b0;
               state_d = CMD55;
            end else begin
               timer_d = timer_q + 21'd1;
            end
         end
         CMD0, CMD8, CMD58A, CMD55, ACMD41, CMD58B: begin
            if (!wait_q) begin
               if (!eng_req_q) begin
                  eng_req_d      = 1'b1;
                  eng_cmd_d      = frame;
                  eng_resp_len_d = frame_len;
               end else if (eng_ack) begin
                  eng_req_d = 1'b0;
                  wait_d    = 1'b1;
               end
            end else if (eng_timeout || eng_done) begin
               wait_d = 1'b0;
               // A timeout always takes priority over a simultaneous done.
               if (state_q == CMD0) begin
                  if (!eng_timeout && r1 == 8'h01) begin
                     state_d = CMD8;
                  end else if (cmd0_cnt_q >= C0_LAST) begin
                     fail_code = 3'd1;
                  end else begin
                     cmd0_cnt_d = cmd0_cnt_q + 1'b1;
                  end
               end else if (eng_timeout) begin
                  fail_code = 3'd7;
               end else begin
                  case (state_q)
                     CMD8: begin
                        if (r1 == 8'h05) begin
                           v1_d    = 1'b1;
                           state_d = CMD58A;
                        end else if (r1 == 8'h01 && eng_resp[11:8] == 4'h1 &&
                                     eng_resp[7:0] == 8'hAA) begin
                           v1_d    = 1'b0;
                           state_d = CMD58A;
                        end else begin
                           fail_code = 3'd2;
                        end
                     end
                     CMD58A: begin
                        if (r1 == 8'h01 && (eng_resp[20] || eng_resp[21])) begin
                           a41_cnt_d = '0;
                           state_d   = CMD55;
                        end else begin
                           fail_code = 3'd3;
                        end
                     end
                     CMD55: begin
                        if (r1 == 8'h00 || r1 == 8'h01) state_d = ACMD41;
                        else                            fail_code = 3'd4;
                     end
                     ACMD41: begin
                        if (r1 == 8'h00) begin
                           if (v1_q) begin
                              state_d     = DONE;
                              done_d      = 1'b1;
                              busy_d      = 1'b0;
                              card_sdhc_d = 1'b0;
                              fast_clk_d  = 1'b1;
                           end else begin
                              state_d = CMD58B;
                           end
                        end else if (r1 == 8'h01) begin
                           if (a41_cnt_q >= A41_LAST) begin
                              fail_code = 3'd5;
                           end else begin
                              a41_cnt_d = a41_cnt_q + 1'b1;
                              timer_d   = '0;
                              state_d   = GAP;
                           end
                        end else begin
                           fail_code = 3'd4;
                        end
                     end
                     CMD58B: begin
                        if (r1 == 8'h00) begin
                           state_d     = DONE;
                           done_d      = 1'b1;
                           busy_d      = 1'b0;
                           card_sdhc_d = eng_resp[30];
                           fast_clk_d  = 1'b1;
                        end else begin
                           fail_code = 3'd6;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail_code != 3'd0) begin
         state_d    = ERROR;
         error_d    = 1'b1;
         err_code_d = fail_code;
         busy_d     = 1'b0;
         cs_n_d     = 1'b1;
         fast_clk_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         wait_q         <= 1'b0;
         v1_q           <= 1'b0;
         timer_q        <= '0;
         cmd0_cnt_q     <= '0;
         a41_cnt_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         err_code_q     <= 3'd0;
         card_sdhc_q    <= 1'b0;
         fast_clk_q     <= 1'b0;
         cs_n_q         <= 1'b1;
         eng_req_q      <= 1'b0;
         eng_cmd_q      <= '0;
         eng_resp_len_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         v1_q           <= v1_d;
         timer_q        <= timer_d;
         cmd0_cnt_q     <= cmd0_cnt_d;
         a41_cnt_q      <= a41_cnt_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
         err_code_q     <= err_code_d;
         card_sdhc_q    <= card_sdhc_d;
         fast_clk_q     <= fast_clk_d;
         cs_n_q         <= cs_n_d;
         eng_req_q      <= eng_req_d;
         eng_cmd_q      <= eng_cmd_d;
         eng_resp_len_q <= eng_resp_len_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_code_q;
   assign card_sdhc    = card_sdhc_q;
   assign fast_clk     = fast_clk_q;
   assign cs_n         = cs_n_q;
   assign eng_req      = eng_req_q;
   assign eng_cmd      = eng_cmd_q;
   assign eng_resp_len = eng_resp_len_q;
endmodule
